// File: rtl/hazard_pkg.sv
// Shared encodings and helpers for the pipeline hazard controller.
package hazard_pkg;

    localparam int TNEW_W = 2;

    typedef enum logic [1:0] {
        FWD_GRF = 2'd0,
        FWD_E   = 2'd1,
        FWD_M   = 2'd2,
        FWD_W   = 2'd3
    } fwd_sel_e;

    localparam logic [TNEW_W-1:0] TUSE_NONE = 2'd3;

    // Tnew counts down one per stage but never wraps below zero.
    function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Busy timer for the multi-cycle mult/div unit; loads when the op sits in E, then counts down.
module md_busy_counter #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;

    // A second op is held in D while busy, so start never overlaps a non-zero count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (start) begin
            cnt_q <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign busy = start | (cnt_q != '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall, bubble and forwarding control for the F/D/E/M/W pipeline, tracking dst/Tnew per stage.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        D_rs,
    input  logic [4:0]        D_rt,
    input  logic [TNEW_W-1:0] D_tuse_rs,
    input  logic [TNEW_W-1:0] D_tuse_rt,
    input  logic [4:0]        D_dst,
    input  logic [TNEW_W-1:0] D_tnew,
    input  logic              D_md_start,
    input  logic              D_md_div,
    input  logic              D_uses_md,
    output logic              stall,
    output logic [1:0]        D_fwd_rs,
    output logic [1:0]        D_fwd_rt,
    output logic [1:0]        E_fwd_rs,
    output logic [1:0]        E_fwd_rt,
    output logic              M_fwd_rt,
    output logic              md_busy
);

    logic [4:0]        E_dst_q, E_rs_q, E_rt_q;
    logic [TNEW_W-1:0] E_tnew_q;
    logic              E_md_q, E_div_q;
    logic [4:0]        M_dst_q, M_rt_q;
    logic [TNEW_W-1:0] M_tnew_q;
    logic [4:0]        W_dst_q;

    logic     stall_rs, stall_rt, stall_md, stall_c;
    logic     md_busy_w;
    fwd_sel_e d_fwd_rs_c, d_fwd_rt_c, e_fwd_rs_c, e_fwd_rt_c;

    function automatic logic reg_hazard(input logic [4:0] r, input logic [TNEW_W-1:0] tuse,
                                        input logic [4:0] e_dst, input logic [TNEW_W-1:0] e_tnew,
                                        input logic [4:0] m_dst, input logic [TNEW_W-1:0] m_tnew);
        return (r != 5'd0) && (((r == e_dst) && (e_tnew > tuse)) ||
                               ((r == m_dst) && (m_tnew > tuse)));
    endfunction

    function automatic fwd_sel_e d_sel(input logic [4:0] r,
                                       input logic [4:0] e_dst, input logic [TNEW_W-1:0] e_tnew,
                                       input logic [4:0] m_dst, input logic [TNEW_W-1:0] m_tnew,
                                       input logic [4:0] w_dst);
        if (r == 5'd0)                         return FWD_GRF;
        if ((r == e_dst) && (e_tnew == '0))    return FWD_E;
        if ((r == m_dst) && (m_tnew == '0))    return FWD_M;
        if (r == w_dst)                        return FWD_W;
        return FWD_GRF;
    endfunction

    function automatic fwd_sel_e e_sel(input logic [4:0] r,
                                       input logic [4:0] m_dst, input logic [TNEW_W-1:0] m_tnew,
                                       input logic [4:0] w_dst);
        if (r == 5'd0)                         return FWD_GRF;
        if ((r == m_dst) && (m_tnew == '0))    return FWD_M;
        if (r == w_dst)                        return FWD_W;
        return FWD_GRF;
    endfunction

    md_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy (
        .clk    (clk),
        .rst    (rst),
        .start  (E_md_q),
        .is_div (E_div_q),
        .busy   (md_busy_w)
    );

    always_comb begin
        stall_rs = reg_hazard(D_rs, D_tuse_rs, E_dst_q, E_tnew_q, M_dst_q, M_tnew_q);
        stall_rt = reg_hazard(D_rt, D_tuse_rt, E_dst_q, E_tnew_q, M_dst_q, M_tnew_q);
        stall_md = D_uses_md & md_busy_w;
        stall_c  = stall_rs | stall_rt | stall_md;
    end

    always_comb begin
        d_fwd_rs_c = d_sel(D_rs, E_dst_q, E_tnew_q, M_dst_q, M_tnew_q, W_dst_q);
        d_fwd_rt_c = d_sel(D_rt, E_dst_q, E_tnew_q, M_dst_q, M_tnew_q, W_dst_q);
        e_fwd_rs_c = e_sel(E_rs_q, M_dst_q, M_tnew_q, W_dst_q);
        e_fwd_rt_c = e_sel(E_rt_q, M_dst_q, M_tnew_q, W_dst_q);
    end

    // On stall the D/E register takes a bubble while M and W keep draining.
    always_ff @(posedge clk) begin
        if (rst) begin
            E_dst_q  <= '0;
            E_rs_q   <= '0;
            E_rt_q   <= '0;
            E_tnew_q <= '0;
            E_md_q   <= 1'b0;
            E_div_q  <= 1'b0;
            M_dst_q  <= '0;
            M_rt_q   <= '0;
            M_tnew_q <= '0;
            W_dst_q  <= '0;
        end else begin
            if (stall_c) begin
                E_dst_q  <= '0;
                E_rs_q   <= '0;
                E_rt_q   <= '0;
                E_tnew_q <= '0;
                E_md_q   <= 1'b0;
                E_div_q  <= 1'b0;
            end else begin
                E_dst_q  <= D_dst;
                E_rs_q   <= D_rs;
                E_rt_q   <= D_rt;
                E_tnew_q <= D_tnew;
                E_md_q   <= D_md_start;
                E_div_q  <= D_md_start & D_md_div;
            end
            M_dst_q  <= E_dst_q;
            M_rt_q   <= E_rt_q;
            M_tnew_q <= tnew_dec(E_tnew_q);
            W_dst_q  <= M_dst_q;
        end
    end

    assign stall    = stall_c;
    assign D_fwd_rs = d_fwd_rs_c;
    assign D_fwd_rt = d_fwd_rt_c;
    assign E_fwd_rs = e_fwd_rs_c;
    assign E_fwd_rt = e_fwd_rt_c;
    assign M_fwd_rt = (M_rt_q != 5'd0) && (M_rt_q == W_dst_q);
    assign md_busy  = md_busy_w;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: each D-stage cycle pushes hand-derived expected outputs.
module tb_hazard_stall_ctrl;

    typedef struct packed {
        logic [4:0] rs;
        logic [1:0] tuse_rs;
        logic [4:0] rt;
        logic [1:0] tuse_rt;
        logic [4:0] dst;
        logic [1:0] tnew;
        logic       md_start;
        logic       md_div;
        logic       uses_md;
    } instr_t;

    typedef struct packed {
        logic       stall;
        logic [1:0] dfrs;
        logic [1:0] dfrt;
        logic [1:0] efrs;
        logic [1:0] efrt;
        logic       mfrt;
        logic       busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] D_rs = '0, D_rt = '0, D_dst = '0;
    logic [1:0] D_tuse_rs = 2'd3, D_tuse_rt = 2'd3, D_tnew = '0;
    logic       D_md_start = 1'b0, D_md_div = 1'b0, D_uses_md = 1'b0;
    logic       stall, M_fwd_rt, md_busy;
    logic [1:0] D_fwd_rs, D_fwd_rt, E_fwd_rs, E_fwd_rt;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_step   = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .D_rs       (D_rs),
        .D_rt       (D_rt),
        .D_tuse_rs  (D_tuse_rs),
        .D_tuse_rt  (D_tuse_rt),
        .D_dst      (D_dst),
        .D_tnew     (D_tnew),
        .D_md_start (D_md_start),
        .D_md_div   (D_md_div),
        .D_uses_md  (D_uses_md),
        .stall      (stall),
        .D_fwd_rs   (D_fwd_rs),
        .D_fwd_rt   (D_fwd_rt),
        .E_fwd_rs   (E_fwd_rs),
        .E_fwd_rt   (E_fwd_rt),
        .M_fwd_rt   (M_fwd_rt),
        .md_busy    (md_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    function automatic instr_t ins(input int rs, input int tus, input int rt, input int tut,
                                   input int dst, input int tnew,
                                   input bit mds, input bit mdd, input bit umd);
        instr_t i;
        i.rs = 5'(rs);  i.tuse_rs = 2'(tus);
        i.rt = 5'(rt);  i.tuse_rt = 2'(tut);
        i.dst = 5'(dst); i.tnew = 2'(tnew);
        i.md_start = mds; i.md_div = mdd; i.uses_md = umd;
        return i;
    endfunction

    function automatic exp_t ex(input bit st, input int dfrs, input int dfrt,
                                input int efrs, input int efrt, input bit mfrt, input bit busy);
        exp_t e;
        e.stall = st; e.dfrs = 2'(dfrs); e.dfrt = 2'(dfrt);
        e.efrs = 2'(efrs); e.efrt = 2'(efrt); e.mfrt = mfrt; e.busy = busy;
        return e;
    endfunction

    task automatic step(input instr_t i, input exp_t e, input logic r);
        rst        = r;
        D_rs       = i.rs;   D_tuse_rs = i.tuse_rs;
        D_rt       = i.rt;   D_tuse_rt = i.tuse_rt;
        D_dst      = i.dst;  D_tnew    = i.tnew;
        D_md_start = i.md_start;
        D_md_div   = i.md_div;
        D_uses_md  = i.uses_md;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk($sformatf("s%0d.stall", n_step),    32'(stall),    32'(e.stall));
            chk($sformatf("s%0d.D_fwd_rs", n_step), 32'(D_fwd_rs), 32'(e.dfrs));
            chk($sformatf("s%0d.D_fwd_rt", n_step), 32'(D_fwd_rt), 32'(e.dfrt));
            chk($sformatf("s%0d.E_fwd_rs", n_step), 32'(E_fwd_rs), 32'(e.efrs));
            chk($sformatf("s%0d.E_fwd_rt", n_step), 32'(E_fwd_rt), 32'(e.efrt));
            chk($sformatf("s%0d.M_fwd_rt", n_step), 32'(M_fwd_rt), 32'(e.mfrt));
            chk($sformatf("s%0d.md_busy", n_step),  32'(md_busy),  32'(e.busy));
            n_step++;
        end
    end

    initial begin
        instr_t nop, beq8, mflo, mfhi, div_i;
        exp_t   z, md_st;
        nop   = ins(0, 3, 0, 3, 0, 0, 0, 0, 0);
        beq8  = ins(8, 0, 0, 0, 0, 0, 0, 0, 0);
        mflo  = ins(0, 3, 0, 3, 6, 1, 0, 0, 1);
        mfhi  = ins(0, 3, 0, 3, 7, 1, 0, 0, 1);
        div_i = ins(4, 1, 5, 1, 0, 0, 1, 1, 1);
        z     = ex(0, 0, 0, 0, 0, 0, 0);
        md_st = ex(1, 0, 0, 0, 0, 0, 1);

        @(posedge clk);
        @(posedge clk);
        #1;

        // idle after reset
        step(nop, z, 0);
        step(nop, z, 0);

        // lw $8 then beq $8: two stall cycles, then W forward
        step(ins(29, 1, 0, 3, 8, 2, 0, 0, 0), z, 0);
        step(beq8, ex(1, 0, 0, 0, 0, 0, 0), 0);
        step(beq8, ex(1, 0, 0, 0, 0, 0, 0), 0);
        step(beq8, ex(0, 3, 0, 0, 0, 0, 0), 0);

        // addu $9 then addu using $9 at E: no stall, E_fwd_rs = M
        step(ins(1, 1, 2, 1, 9, 1, 0, 0, 0), z, 0);
        step(ins(9, 1, 3, 1, 10, 1, 0, 0, 0), z, 0);
        step(nop, ex(0, 0, 0, 2, 0, 0, 0), 0);

        // store-data paths: D rt from M, E rt from W, E rt from M, M rt from W
        step(ins(0, 1, 10, 2, 0, 0, 0, 0, 0), ex(0, 0, 2, 0, 0, 0, 0), 0);
        step(ins(0, 3, 0, 3, 11, 1, 0, 0, 0), ex(0, 0, 0, 0, 3, 0, 0), 0);
        step(ins(0, 1, 11, 2, 0, 0, 0, 0, 0), z, 0);
        step(nop, ex(0, 0, 0, 0, 2, 0, 0), 0);
        step(nop, ex(0, 0, 0, 0, 0, 1, 0), 0);

        // $0 never hazards or forwards even with E_tnew = 2
        step(ins(0, 3, 0, 3, 0, 2, 0, 0, 0), z, 0);
        step(ins(0, 0, 0, 0, 0, 0, 0, 0, 0), z, 0);

        // E and M both write $12 with Tnew 0: E wins
        step(ins(0, 3, 0, 3, 12, 1, 0, 0, 0), z, 0);
        step(ins(0, 3, 0, 3, 12, 0, 0, 0, 0), z, 0);
        step(ins(12, 0, 0, 3, 0, 0, 0, 0, 0), ex(0, 1, 0, 0, 0, 0, 0), 0);

        // mult then mflo: 6 stall cycles
        step(ins(4, 1, 5, 1, 0, 0, 1, 0, 1), ex(0, 0, 0, 2, 0, 0, 0), 0);
        repeat (6) step(mflo, md_st, 0);
        step(mflo, z, 0);
        step(nop, z, 0);

        // div then mfhi: 11 stall cycles
        step(div_i, z, 0);
        repeat (11) step(mfhi, md_st, 0);
        step(mfhi, z, 0);
        step(nop, z, 0);

        // div, then reset while the counter holds 4; queued mfhi proceeds
        step(div_i, z, 0);
        repeat (7) step(mfhi, md_st, 0);
        step(mfhi, md_st, 1);
        step(mfhi, z, 0);
        step(nop, z, 0);

        repeat (2) @(posedge clk);
        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
